// File: rtl/alu.sv
// Registered 8-bit ALU: one combinational result stage feeding a 16-bit output register.
// Operands are zero-extended to 16 bits; every command encoding is defined.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  input  logic [3:0]  command_in,
  input  logic        enable_in,
  output logic [15:0] out
);

  typedef enum logic [3:0] {
    CmdAdd  = 4'b0000,
    CmdSub  = 4'b0001,
    CmdAnd  = 4'b0010,
    CmdOr   = 4'b0011,
    CmdNot  = 4'b0100,
    CmdXor  = 4'b0101,
    CmdNand = 4'b0110,
    CmdNor  = 4'b0111,
    CmdXnor = 4'b1000,
    CmdMul  = 4'b1001,
    CmdShl  = 4'b1010,
    CmdShr  = 4'b1011,
    CmdInc  = 4'b1100,
    CmdDec  = 4'b1101,
    CmdRol  = 4'b1110,
    CmdRor  = 4'b1111
  } cmd_e;

  logic [15:0] aExt;
  logic [15:0] bExt;
  logic [15:0] out_d;
  logic [15:0] out_q;
  cmd_e        cmd;

  assign aExt = {8'h00, a_in};
  assign bExt = {8'h00, b_in};
  assign cmd  = cmd_e'(command_in);

  always_comb begin
    out_d = out_q;
    if (enable_in) begin
      case (cmd)
        CmdAdd:  out_d = aExt + bExt;
        CmdSub:  out_d = aExt - bExt;
        CmdAnd:  out_d = {8'h00, a_in & b_in};
        CmdOr:   out_d = {8'h00, a_in | b_in};
        CmdNot:  out_d = {8'h00, ~a_in};
        CmdXor:  out_d = {8'h00, a_in ^ b_in};
        CmdNand: out_d = {8'h00, ~(a_in & b_in)};
        CmdNor:  out_d = {8'h00, ~(a_in | b_in)};
        CmdXnor: out_d = {8'h00, ~(a_in ^ b_in)};
        CmdMul:  out_d = aExt * bExt;
        CmdShl:  out_d = aExt << 1;
        CmdShr:  out_d = aExt >> 1;
        CmdInc:  out_d = aExt + 16'd1;
        CmdDec:  out_d = aExt - 16'd1;
        CmdRol:  out_d = {8'h00, a_in[6:0], a_in[7]};
        CmdRor:  out_d = {8'h00, a_in[0], a_in[7:1]};
        default: out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 16'h0000;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes hand-computed expectations, a monitor
// pops and compares one entry just after each rising edge.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic [3:0]  command_in;
  logic        enable_in;
  logic [15:0] out;

  typedef struct {
    string       name;
    logic [15:0] expected;
  } sb_entry_t;

  sb_entry_t scoreboard[$];
  int checks = 0;
  int errors = 0;

  alu dut (
    .clk(clk),
    .rst(rst),
    .a_in(a_in),
    .b_in(b_in),
    .command_in(command_in),
    .enable_in(enable_in),
    .out(out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge and records what out must hold after the next rising edge.
  task automatic applyStimulus(input string name, input logic [3:0] cmd, input logic [7:0] a,
                               input logic [7:0] b, input logic en, input logic [15:0] expected);
    sb_entry_t e;
    @(negedge clk);
    command_in = cmd;
    a_in       = a;
    b_in       = b;
    enable_in  = en;
    e.name     = name;
    e.expected = expected;
    scoreboard.push_back(e);
  endtask

  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput(e.name, out, e.expected);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    enable_in  = 1'b0;
    command_in = 4'h0;
    a_in       = 8'h00;
    b_in       = 8'h00;
    #2;
    checkOutput("reset_initial", out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("add_20_10",   4'b0000, 8'd20,  8'd10,  1'b1, 16'd30);
    applyStimulus("sub_20_30",   4'b0001, 8'd20,  8'd30,  1'b1, 16'hFFF6);
    applyStimulus("and_6_4",     4'b0010, 8'd6,   8'd4,   1'b1, 16'd4);
    applyStimulus("or_6_4",      4'b0011, 8'd6,   8'd4,   1'b1, 16'd6);
    applyStimulus("not_5",       4'b0100, 8'd5,   8'h33,  1'b1, 16'd250);
    applyStimulus("xor_f0_3c",   4'b0101, 8'hF0,  8'h3C,  1'b1, 16'h00CC);
    applyStimulus("nand_6_4",    4'b0110, 8'd6,   8'd4,   1'b1, 16'h00FB);
    applyStimulus("nor_6_4",     4'b0111, 8'd6,   8'd4,   1'b1, 16'h00F9);
    applyStimulus("xnor_f0_3c",  4'b1000, 8'hF0,  8'h3C,  1'b1, 16'h0033);
    applyStimulus("mul_255_255", 4'b1001, 8'd255, 8'd255, 1'b1, 16'd65025);
    applyStimulus("mul_16_16",   4'b1001, 8'd16,  8'd16,  1'b1, 16'd256);
    applyStimulus("shl_81",      4'b1010, 8'h81,  8'h00,  1'b1, 16'h0102);
    applyStimulus("shr_81",      4'b1011, 8'h81,  8'hFF,  1'b1, 16'h0040);
    applyStimulus("inc_255",     4'b1100, 8'd255, 8'd0,   1'b1, 16'd256);
    applyStimulus("dec_0",       4'b1101, 8'd0,   8'd0,   1'b1, 16'hFFFF);
    applyStimulus("dec_1",       4'b1101, 8'd1,   8'd0,   1'b1, 16'h0000);
    applyStimulus("rol_81",      4'b1110, 8'h81,  8'h00,  1'b1, 16'h0003);
    applyStimulus("ror_81",      4'b1111, 8'h81,  8'h00,  1'b1, 16'h00C0);
    applyStimulus("add_255_255", 4'b0000, 8'd255, 8'd255, 1'b1, 16'd510);

    // Enable low: out must keep the ADD result whatever the other inputs do.
    applyStimulus("hold_load",   4'b0000, 8'd20,  8'd10,  1'b1, 16'd30);
    applyStimulus("hold_1",      4'b1001, 8'd200, 8'd3,   1'b0, 16'd30);
    applyStimulus("hold_2",      4'b0100, 8'd7,   8'd99,  1'b0, 16'd30);
    applyStimulus("hold_3",      4'b1101, 8'd0,   8'd1,   1'b0, 16'd30);

    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset_async", out, 16'h0000);
    applyStimulus("reset_hold_1", 4'b0000, 8'd20, 8'd10, 1'b1, 16'h0000);
    applyStimulus("reset_hold_2", 4'b1001, 8'd9,  8'd9,  1'b1, 16'h0000);
    @(negedge clk);
    rst       = 1'b0;
    enable_in = 1'b0;
    applyStimulus("after_reset_mul", 4'b1001, 8'd12, 8'd12, 1'b1, 16'd144);
    applyStimulus("after_reset_sub", 4'b0001, 8'd50, 8'd8,  1'b1, 16'd42);

    repeat (20) begin
      if (scoreboard.size() != 0) @(posedge clk);
    end
    #2;
    if (scoreboard.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending entries expected 0", scoreboard.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high; clears all state immediately.
REQ-004 a_in  input  8  operand A, unsigned.
REQ-005 b_in  input  8  operand B, unsigned.
REQ-006 command_in  input  4  operation select (encoding in Function).
REQ-007 enable_in  input  1  operation enable; 1 = compute and load result this cycle.
REQ-008 out  output  16  registered result.

Function
REQ-009 out SHALL be a register; on a rising clk edge with rst=0 and enable_in=1, out SHALL load the result of command_in applied to the a_in and b_in values sampled at that edge (latency 1 cycle).
REQ-010 On a rising clk edge with enable_in=0, out SHALL hold its previous value.
REQ-011 Operands SHALL be zero-extended to 16 bits before any arithmetic, and arithmetic results SHALL be taken modulo 2^16.
REQ-012 Command encoding SHALL be as follows:
- 0000 ADD: out = a + b, range 0..510.
- 0001 SUB: out = a - b, 16-bit two's complement; a < b wraps (20-30 = 16'hFFF6).
- 0010 AND: out = {8'h00, a & b}.
- 0011 OR: out = {8'h00, a | b}.
- 0100 NOT: out = {8'h00, ~a}; b is ignored.
- 0101 XOR: out = {8'h00, a ^ b}.
- 0110 NAND: out = {8'h00, ~(a & b)}.
- 0111 NOR: out = {8'h00, ~(a | b)}.
- 1000 XNOR: out = {8'h00, ~(a ^ b)}.
- 1001 MUL: out = a * b, full 16-bit unsigned product.
- 1010 SHL: out = a << 1 in 16 bits; the carry lands in bit 8.
- 1011 SHR: out = a >> 1, zero-fill.
- 1100 INC: out = a + 1; 255 gives 256.
- 1101 DEC: out = a - 1, modulo 2^16; 0 gives 16'hFFFF.
- 1110 ROL: out = {8'h00, a[6:0], a[7]}.
- 1111 ROR: out = {8'h00, a[0], a[7:1]}.
REQ-013 All 16 encodings are defined, so no input combination SHALL produce X or an unspecified value on out.
REQ-014 Operand or command changes between clock edges SHALL NOT affect out until the next enabled edge.
REQ-015 The result logic SHALL be a single combinational stage feeding the out register, with no multi-cycle paths.

Reset
REQ-016 Asserting rst SHALL force out to 16'h0000 immediately, independent of clk.
REQ-017 While rst=1, out SHALL stay 0 regardless of enable_in, command_in or operands.
REQ-018 After rst deasserts, the first rising edge with enable_in=1 SHALL load a valid result; a reset in the middle of a sequence SHALL discard any pending result.

Verification
REQ-019 Basic arithmetic and logic:
- enable_in=1, a=20, b=10, ADD -> out=30 after one edge.
- a=20, b=30, SUB -> out=65526 (16'hFFF6).
REQ-020 Logic ops with a=6, b=4: AND -> out=4; OR -> out=6.
REQ-021 NOT and unary ops:
- a=5, NOT -> out=250.
- a=255, INC -> 256.
- a=0, DEC -> 16'hFFFF.
- a=8'h81, ROL -> 16'h0003; ROR -> 16'h00C0.
REQ-022 Multiply: a=255, b=255, MUL -> out=65025.
REQ-023 Enable hold: load ADD 20+10, then drop enable_in and change the operands and command -> out stays 30 across several edges.
REQ-024 Asynchronous reset: with out=30, assert rst between clock edges -> out=0 before the next edge; out stays 0 while rst=1 even with enable_in=1.
